slicer_mer: RTL and testbench
=============================

Name: slicer_mer

Overview:
- Symbol-rate decision stage directly downstream of the receive matched-filter path.
- Consumes the 18-bit decision variable once per symbol and slices it to a 2-bit 4-level symbol, using the same encoding the upstream mapper feeds into the pulse filters.
- Adaptively estimates the constellation scale from a block-window mean of |x|.
- Reports windowed mean-squared error so the filter-path switch can be compared on-chip.

Parameters:
- DW, 18, decision-variable width, signed 1s17.
- LOG2_WIN, 10, log2 of the averaging window in symbols (default 1024).
- DEFAULT_MEAN, 18'sd32768, mean-|x| value used before first window completes.

Ports:
- sys_clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- sym_clk_ena  in  1  one-sys_clk-wide symbol strobe; x_in is sampled when high.
- x_in  in  DW  signed decision variable.
- sym_out  out  2  sliced symbol: 00=-3a, 01=-a, 10=+a, 11=+3a.
- sym_valid  out  1  one-cycle pulse, sym_out updated.
- mean_abs  out  DW  current unsigned mean-|x| estimate (2a).
- msq_err  out  2*DW-2  mean squared error of the last completed window.
- window_done  out  1  one-cycle pulse when mean_abs/msq_err update.
- locked  out  1  high once the first window has completed.
- low_conf_cnt  out  LOG2_WIN+1  low-confidence count (optional feature, see below).

Behaviour:
- Reset (async assert, sync-safe deassert on sys_clk):
  - sym_out=00, sym_valid=0, window_done=0, locked=0, msq_err=0, low_conf_cnt=0.
  - mean_abs=DEFAULT_MEAN; all accumulators and the symbol counter cleared; FSM in ACQ.
- Thresholds from M=mean_abs: T_hi=M, T_lo=-M, T_0=0. Ideal levels: a=M>>1, 3a=a+(a<<1).
- Slicing, evaluated at the strobe cycle t, registered at t+1 with sym_valid=1:
  - x>=T_hi gives 11; T_0<=x<T_hi gives 10; T_lo<=x<T_0 gives 01; x<T_lo gives 00.
  - Ties go to the upper region, so x=0 gives 10.
- Error pipeline:
  - At t+1: e=x - ideal(sym), computed DW+2 bits wide, then clipped to ±(2^(DW-1)-1).
  - At t+2: e*e (2*DW-2 bits, unsigned) is added to err_acc (2*DW-2+LOG2_WIN bits). No overflow is possible by construction.
  - |x| is accumulated at t+1 into abs_acc (DW+LOG2_WIN bits). |-2^(DW-1)| saturates to 2^(DW-1)-1.
- Symbol counter (LOG2_WIN bits):
  - Increments at t+1 of each strobe.
  - When the 2^LOG2_WIN-th symbol's square is added (t+2 of the last symbol), and in that same cycle:
    - mean_abs <= abs_acc>>LOG2_WIN.
    - msq_err <= (err_acc+last_sq)>>LOG2_WIN.
    - window_done=1.
    - Accumulators clear.
  - The counter wraps to 0.
- FSM:
  - ACQ: locked=0, thresholds use DEFAULT_MEAN. On the first window_done, go to TRACK.
  - TRACK: locked=1, thresholds use the latest mean_abs. Stays in TRACK until reset.
- Strobe spacing: strobes are at least 3 sys_clk apart. A strobe in the window_done cycle is accumulated into the new window, not lost.
- A computed mean_abs of 0 is clamped to 1 so thresholds never collapse.
- Reset mid-window discards the partial window; the block returns to ACQ.

Optional Feature:
- Macro SLICER_LOW_CONF_EN.
- Defined:
  - Count symbols in the window with |e| > (a>>1).
  - low_conf_cnt loads the count on window_done, with the same timing as msq_err.
  - Counter saturates at 2^LOG2_WIN.
- Undefined: low_conf_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, then 4 strobes with x=+60000, +20000, -20000, -60000 (ACQ, M=32768) -> sym_out 11,10,01,00, each with sym_valid one cycle after its strobe; locked=0.
- Boundary: x=0, 32768, -32768, 32767 in ACQ -> 10, 11, 01, 10.
- 1024 strobes alternating +-16384 and +-49152 equally -> window_done one cycle after the 1024th square is added:
  - mean_abs=32768, msq_err=0, locked=1.
  - low_conf_cnt=0 if SLICER_LOW_CONF_EN.
- 1024 strobes of constant x=+20000 after lock (M=32768, a=16384) -> e=3616 each:
  - msq_err=13075456.
  - next mean_abs=20000, so thresholds move to ±20000.
- Scale tracking: window of ±8192/±24576 after lock -> mean_abs=16384; following x=+20000 slices to 11.
- Assert reset_n low mid-window (symbol 500) -> outputs are at reset values immediately; after release, a full 1024 symbols are needed before window_done.

Source files
------------

// File: rtl/slicer_mer_if.sv
// Slicer bus: symbol strobe and decision variable in, sliced symbol and window statistics out.
interface slicer_mer_if #(
  parameter int unsigned DW       = 18,
  parameter int unsigned LOG2_WIN = 10
);
  logic                 sym_clk_ena;
  logic signed [DW-1:0] x_in;
  logic [1:0]           sym_out;
  logic                 sym_valid;
  logic [DW-1:0]        mean_abs;
  logic [2*DW-3:0]      msq_err;
  logic                 window_done;
  logic                 locked;
  logic [LOG2_WIN:0]    low_conf_cnt;

  modport master (output sym_clk_ena, x_in,
                  input  sym_out, sym_valid, mean_abs, msq_err, window_done, locked, low_conf_cnt);
  modport slave  (input  sym_clk_ena, x_in,
                  output sym_out, sym_valid, mean_abs, msq_err, window_done, locked, low_conf_cnt);
endinterface

// File: rtl/slicer_mer.sv
// 4-level symbol slicer with adaptive mean-|x| thresholds and windowed mean-squared error.
// Define SLICER_LOW_CONF_EN to build the per-window low-confidence counter.
module slicer_mer #(
  parameter int unsigned          DW           = 18,
  parameter int unsigned          LOG2_WIN     = 10,
  parameter logic signed [DW-1:0] DEFAULT_MEAN = 18'sd32768
) (
  input logic         sys_clk,
  input logic         reset_n,
  slicer_mer_if.slave bus
);
  localparam int unsigned EW = DW + 2;
  localparam int unsigned SW = 2*DW - 2;
  localparam int unsigned AW = DW + LOG2_WIN;
  localparam int unsigned QW = SW + LOG2_WIN;
  localparam logic [DW-2:0]        MAG_MAX = {(DW-1){1'b1}};
  localparam logic signed [EW-1:0] E_MAX   = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] X_MIN   = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        m_eff;
  logic signed [DW-1:0] x_d;
  logic [DW-2:0]        e_mag_q;
  logic                 v2_q, last_q;
  logic [LOG2_WIN-1:0]  sym_cnt;
  logic [AW-1:0]        abs_acc;
  logic [QW-1:0]        err_acc;

  logic signed [EW-1:0] x_s, m_s, xd_s, a_w, a3_w, ideal_c, e_w, e_abs_w;
  logic [1:0]           slice_c;
  logic [DW-2:0]        e_mag_c;
  logic [DW-1:0]        abs_c, mean_c;
  logic [SW-1:0]        sq_c;
  logic [QW-1:0]        err_sum_c;
  logic                 win_end_c;

  // State register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACQ;
    else          state_q <= state_d;
  end

  // Next state: the first completed window locks the thresholds to the estimate
  always_comb begin
    state_d = state_q;
    if (state_q == ACQ && win_end_c) state_d = TRACK;
  end

  // Output decode
  always_comb begin
    bus.locked = 1'b0;
    m_eff      = DEFAULT_MEAN;
    if (state_q == TRACK) begin
      bus.locked = 1'b1;
      m_eff      = bus.mean_abs;
    end
  end

  // Slicer, error magnitude, |x| and square
  always_comb begin
    x_s  = EW'(signed'(bus.x_in));
    m_s  = EW'(m_eff);
    if (x_s >= m_s)       slice_c = 2'b11;
    else if (!x_s[EW-1])  slice_c = 2'b10;
    else if (x_s >= -m_s) slice_c = 2'b01;
    else                  slice_c = 2'b00;

    a_w  = EW'(m_eff >> 1);
    a3_w = a_w + (a_w <<< 1);
    case (bus.sym_out)
      2'b11:   ideal_c = a3_w;
      2'b10:   ideal_c = a_w;
      2'b01:   ideal_c = -a_w;
      default: ideal_c = -a3_w;
    endcase
    xd_s    = EW'(x_d);
    e_w     = xd_s - ideal_c;
    e_abs_w = e_w[EW-1] ? -e_w : e_w;
    e_mag_c = (e_abs_w > E_MAX) ? MAG_MAX : e_abs_w[DW-2:0];

    abs_c = x_d[DW-1] ? DW'(-x_d) : DW'(x_d);
    if (x_d == X_MIN) abs_c = {1'b0, MAG_MAX};

    sq_c      = SW'(e_mag_q) * SW'(e_mag_q);
    err_sum_c = err_acc + QW'(sq_c);
    mean_c    = abs_acc[AW-1:LOG2_WIN];
    if (mean_c == '0) mean_c = DW'(1);
    win_end_c = v2_q & last_q;
  end

  // Symbol pipeline: slice at the strobe, error and |x| one cycle later, square after that
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sym_out     <= '0;
      bus.sym_valid   <= 1'b0;
      bus.mean_abs    <= DEFAULT_MEAN;
      bus.msq_err     <= '0;
      bus.window_done <= 1'b0;
      x_d             <= '0;
      e_mag_q         <= '0;
      v2_q            <= 1'b0;
      last_q          <= 1'b0;
      sym_cnt         <= '0;
      abs_acc         <= '0;
      err_acc         <= '0;
    end else begin
      bus.sym_valid   <= bus.sym_clk_ena;
      v2_q            <= bus.sym_valid;
      bus.window_done <= win_end_c;
      if (bus.sym_clk_ena) begin
        bus.sym_out <= slice_c;
        x_d         <= bus.x_in;
      end
      if (bus.sym_valid) begin
        e_mag_q <= e_mag_c;
        last_q  <= &sym_cnt;
        sym_cnt <= sym_cnt + LOG2_WIN'(1);
        abs_acc <= abs_acc + AW'(abs_c);
      end
      if (v2_q) begin
        if (last_q) begin
          bus.mean_abs <= mean_c;
          bus.msq_err  <= err_sum_c[QW-1:LOG2_WIN];
          abs_acc      <= '0;
          err_acc      <= '0;
        end else begin
          err_acc <= err_sum_c;
        end
      end
    end
  end

`ifdef SLICER_LOW_CONF_EN
  localparam int unsigned CW = LOG2_WIN + 1;
  localparam logic [CW-1:0] LC_MAX = CW'(1) << LOG2_WIN;

  logic          lc_q;
  logic [CW-1:0] lc_acc, lc_sum_c;

  always_comb begin
    lc_sum_c = lc_acc + CW'(lc_q);
    if (lc_sum_c > LC_MAX) lc_sum_c = LC_MAX;
  end

  // Count symbols whose |e| exceeds a/2; published alongside msq_err
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lc_q             <= 1'b0;
      lc_acc           <= '0;
      bus.low_conf_cnt <= '0;
    end else begin
      if (bus.sym_valid) lc_q <= (signed'(EW'(e_mag_c)) > (a_w >>> 1));
      if (v2_q) begin
        if (last_q) begin
          bus.low_conf_cnt <= lc_sum_c;
          lc_acc           <= '0;
        end else begin
          lc_acc <= lc_sum_c;
        end
      end
    end
  end
`else
  assign bus.low_conf_cnt = '0;
`endif

endmodule

// File: tb/tb_slicer_mer.sv
// Scoreboard bench for slicer_mer: directed and random strobes against a per-window behavioural model.
`timescale 1ns/1ps
module tb_slicer_mer;
  localparam int unsigned DW       = 18;
  localparam int unsigned LOG2_WIN = 10;
  localparam int          WIN      = 1 << LOG2_WIN;
  localparam int          DEF_MEAN = 32768;
  localparam int          XMAX     = 131071;

  logic sys_clk = 1'b0;
  logic reset_n;

  slicer_mer_if #(.DW(DW), .LOG2_WIN(LOG2_WIN)) bus ();
  slicer_mer #(.DW(DW), .LOG2_WIN(LOG2_WIN)) u_dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { logic [1:0] sym; logic locked; logic last; } sym_exp_t;
  typedef struct { int mean; longint msq; int lc; } win_exp_t;

  sym_exp_t sym_q[$];
  win_exp_t win_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int win_deadline = 0;
  bit win_pending = 0;

  // Behavioural model state: one window of plain integer sums
  int     m_mean;
  bit     m_locked;
  int     m_cnt;
  int     m_lc;
  longint m_abs_sum;
  longint m_err_sum;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mean = DEF_MEAN; m_locked = 0; m_cnt = 0; m_lc = 0;
    m_abs_sum = 0; m_err_sum = 0;
  endtask

  task automatic model_symbol(input int x);
    int m, a, sym;
    longint lvl, e, ax;
    sym_exp_t se;
    win_exp_t we;
    m = m_locked ? m_mean : DEF_MEAN;
    a = m / 2;
    if (x >= m)       begin sym = 3; lvl = 3*a;  end
    else if (x >= 0)  begin sym = 2; lvl = a;    end
    else if (x >= -m) begin sym = 1; lvl = -a;   end
    else              begin sym = 0; lvl = -3*a; end
    e = longint'(x) - lvl;
    if (e > XMAX)  e = XMAX;
    if (e < -XMAX) e = -XMAX;
    ax = (x < 0) ? -longint'(x) : longint'(x);
    if (ax > XMAX) ax = XMAX;
    m_err_sum += e * e;
    m_abs_sum += ax;
    if (((e < 0) ? -e : e) > longint'(a / 2)) m_lc++;
    m_cnt++;
    se.sym = 2'(sym); se.locked = m_locked; se.last = (m_cnt == WIN);
    sym_q.push_back(se);
    if (m_cnt == WIN) begin
      we.mean = int'(m_abs_sum / WIN);
      if (we.mean == 0) we.mean = 1;
      we.msq = m_err_sum / WIN;
      we.lc  = (m_lc > WIN) ? WIN : m_lc;
      win_q.push_back(we);
      m_mean = we.mean; m_locked = 1;
      m_cnt = 0; m_lc = 0; m_abs_sum = 0; m_err_sum = 0;
    end
  endtask

  task automatic check_reset();
    check("rst_sym_out", bus.sym_out, 0);
    check("rst_sym_valid", bus.sym_valid, 0);
    check("rst_window_done", bus.window_done, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_msq_err", bus.msq_err, 0);
    check("rst_mean_abs", bus.mean_abs, DEF_MEAN);
    check("rst_low_conf_cnt", bus.low_conf_cnt, 0);
  endtask

  // Caller is aligned 1 ns after a rising edge; strobe lasts one cycle, next strobe gap cycles later
  task automatic strobe(input int x, input int gap);
    bus.x_in = DW'(x);
    bus.sym_clk_ena = 1'b1;
    model_symbol(x);
    @(posedge sys_clk); #1;
    bus.sym_clk_ena = 1'b0;
    repeat (gap - 1) @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    sym_q.delete();
    win_q.delete();
    win_pending = 0;
    @(posedge sys_clk); #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a symbol or a window result
  always @(negedge sys_clk) begin
    cyc++;
    if (reset_n) begin
      if (bus.sym_valid) begin
        if (sym_q.size() == 0) check("sym_valid_unexpected", 1, 0);
        else begin
          sym_exp_t se;
          se = sym_q.pop_front();
          check("sym_out", bus.sym_out, se.sym);
          check("locked_at_sym", bus.locked, se.locked);
          if (se.last) begin win_pending = 1; win_deadline = cyc + 2; end
        end
      end
      if (bus.window_done) begin
        if (!win_pending || win_q.size() == 0) check("window_done_unexpected", 1, 0);
        else begin
          win_exp_t we;
          we = win_q.pop_front();
          win_pending = 0;
          check("window_done_cycle", cyc, win_deadline);
          check("mean_abs", bus.mean_abs, we.mean);
          check("msq_err", bus.msq_err, we.msq);
          check("locked_at_window", bus.locked, 1);
`ifdef SLICER_LOW_CONF_EN
          check("low_conf_cnt", bus.low_conf_cnt, we.lc);
`else
          check("low_conf_cnt", bus.low_conf_cnt, 0);
`endif
        end
      end else if (win_pending && cyc > win_deadline) begin
        check("window_done_missing", 0, 1);
        win_pending = 0;
        if (win_q.size() != 0) void'(win_q.pop_front());
      end
    end
  end

  initial begin
    int dir[8];
    int pat1[4];
    int pat3[4];
    reset_n = 1'b0;
    bus.sym_clk_ena = 1'b0;
    bus.x_in = '0;
    model_reset();
    idle(3);
    check_reset();
    reset_n = 1'b1;
    idle(2);

    // Acquisition slicing with the default scale, including the tie points
    dir = '{60000, 20000, -20000, -60000, 0, 32768, -32768, 32767};
    foreach (dir[i]) strobe(dir[i], 3);
    idle(6);
    do_reset();

    // Window 1: ideal levels at the default scale
    pat1 = '{16384, -16384, 49152, -49152};
    for (int i = 0; i < WIN; i++) strobe(pat1[i % 4], int'($urandom_range(3, 5)));
    idle(6);

    // Window 2: constant offset error after lock
    for (int i = 0; i < WIN; i++) strobe(20000, 3);
    idle(6);

    // Window 3: smaller constellation, then a sample sliced against the new scale
    pat3 = '{8192, -8192, 24576, -24576};
    for (int i = 0; i < WIN; i++) strobe(pat3[i % 4], int'($urandom_range(3, 4)));
    idle(4);
    strobe(20000, 3);

    // Partial random window interrupted by reset at symbol 500
    for (int i = 1; i < 500; i++) strobe(int'($urandom_range(0, 262143)) - 131072, 3);
    idle(5);
    do_reset();

    // Full random window from ACQ, starting with the extremes
    strobe(-131072, 3);
    strobe(131071, 3);
    strobe(0, 3);
    for (int i = 3; i < WIN; i++)
      strobe(int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(3, 6)));
    idle(10);

    check("sym_queue_drained", sym_q.size(), 0);
    check("win_queue_drained", win_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
